// File: rtl/prog_ctr.sv
// Program counter and fetch sequencer: IDLE (wait for start), RUN (fetching), DONE (halted).
// InstAddress drives a combinational ROM; next-PC controls come back decoded from that instruction.
module prog_ctr #(
    parameter int A  = 10,
    parameter int OW = 6,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          start_i,
    input  logic [A-1:0]  start_addr_i,
    input  logic          stall_i,
    input  logic          halt_i,
    input  logic          jump_i,
    input  logic [A-1:0]  jump_target_i,
    input  logic          branch_rel_i,
    input  logic [OW-1:0] offset_i,
    output logic [A-1:0]  inst_address_o,
    output logic          running_o,
    output logic          done_o,
    output logic [CW-1:0] cycle_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [A-1:0]  pc_q;
    logic [A-1:0]  pc_d;
    logic [CW-1:0] cnt_q;
    logic          running_q;
    logic          done_q;

    // Next PC for a non-stalled, non-halting RUN cycle; sums wrap modulo 2^A.
    always_comb begin
        pc_d = pc_q + A'(1);
        if (jump_i) begin
            pc_d = jump_target_i;
        end else if (branch_rel_i) begin
            pc_d = pc_q + {{(A-OW){offset_i[OW-1]}}, offset_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q   <= RUN;
                        pc_q      <= start_addr_i;
                        cnt_q     <= '0;
                        running_q <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt_q != {CW{1'b1}}) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                    if (stall_i) begin
                        pc_q <= pc_q;
                    end else if (halt_i) begin
                        state_q   <= DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        pc_q <= pc_d;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign inst_address_o = pc_q;
    assign running_o      = running_q;
    assign done_o         = done_q;
    assign cycle_cnt_o    = cnt_q;

endmodule

// File: tb/tb_prog_ctr.sv
// Bench for prog_ctr: directed scenarios with literal expectations, then random controls
// checked every cycle against an arithmetic model (two instances: CW=16 and CW=4).
module tb_prog_ctr;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [9:0] start_addr;
    logic       stall;
    logic       halt;
    logic       jump;
    logic [9:0] jump_target;
    logic       branch_rel;
    logic [5:0] offset;

    logic [9:0]  addr16, addr4;
    logic        run16, run4, done16, done4;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prog_ctr #(.A(10), .OW(6), .CW(16)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .start_addr_i(start_addr),
        .stall_i(stall), .halt_i(halt), .jump_i(jump), .jump_target_i(jump_target),
        .branch_rel_i(branch_rel), .offset_i(offset),
        .inst_address_o(addr16), .running_o(run16), .done_o(done16), .cycle_cnt_o(cnt16)
    );

    prog_ctr #(.A(10), .OW(6), .CW(4)) dut4 (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .start_addr_i(start_addr),
        .stall_i(stall), .halt_i(halt), .jump_i(jump), .jump_target_i(jump_target),
        .branch_rel_i(branch_rel), .offset_i(offset),
        .inst_address_o(addr4), .running_o(run4), .done_o(done4), .cycle_cnt_o(cnt4)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=idle, 1=running, 2=halted.
    int m_mode = 0;
    int m_pc = 0;
    int m_cnt = 0;
    int m_cnt4 = 0;
    bit m_valid = 0;

    always @(posedge clk) begin
        int off;
        if (!reset_n) begin
            m_mode = 0; m_pc = 0; m_cnt = 0; m_cnt4 = 0; m_valid = 1;
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode = 1; m_pc = int'(start_addr); m_cnt = 0; m_cnt4 = 0;
            end
        end else begin
            m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
            m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : 15;
            if (stall) begin
                // hold
            end else if (halt) begin
                m_mode = 2;
            end else if (jump) begin
                m_pc = int'(jump_target);
            end else if (branch_rel) begin
                off = int'(offset);
                if (off >= 32) off -= 64;
                m_pc = (m_pc + off + 1024) % 1024;
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
        end
        #1;
        if (m_valid) begin
            check("model_pc",      addr16, m_pc);
            check("model_pc4",     addr4,  m_pc);
            check("model_running", run16,  m_mode == 1);
            check("model_done",    done16, m_mode == 2);
            check("model_run4",    run4,   m_mode == 1);
            check("model_done4",   done4,  m_mode == 2);
            check("model_cnt",     cnt16,  m_cnt);
            check("model_cnt4",    cnt4,   m_cnt4);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_ctl();
        start = 0; stall = 0; halt = 0; jump = 0; branch_rel = 0;
    endtask

    task automatic jump_to(input logic [9:0] t);
        jump = 1; jump_target = t;
        tick();
        jump = 0;
    endtask

    initial begin
        int snap;
        reset_n = 0; start = 1; start_addr = 10'h010; stall = 0; halt = 0;
        jump = 0; jump_target = 0; branch_rel = 0; offset = 0;

        // Reset dominates Start
        tick(); tick();
        check("rst_pc", addr16, 0);
        check("rst_running", run16, 0);
        check("rst_done", done16, 0);
        check("rst_cnt", cnt16, 0);

        reset_n = 1; start = 1; start_addr = 10'h010;
        tick();
        check("start_pc", addr16, 10'h010);
        check("start_running", run16, 1);
        check("start_cnt", cnt16, 0);

        // Start during RUN is ignored
        start_addr = 10'h300;
        tick();
        check("start_in_run_pc", addr16, 10'h011);
        start = 0;

        // Sequential run across the wrap point
        halt = 1; tick(); halt = 0;
        check("halt_done", done16, 1);
        start = 1; start_addr = 10'h3FE; tick(); start = 0;
        check("wrap_pc0", addr16, 10'h3FE);
        tick(); check("wrap_pc1", addr16, 10'h3FF);
        tick(); check("wrap_pc2", addr16, 10'h000);
        tick(); check("wrap_pc3", addr16, 10'h001);
        check("wrap_cnt", cnt16, 3);

        // Relative branches and Jump priority over BranchRel
        jump_to(10'h020);
        branch_rel = 1; offset = 6'b111100; tick();
        check("br_neg", addr16, 10'h01C);
        offset = 6'd31; tick();
        check("br_pos", addr16, 10'h03B);
        jump = 1; jump_target = 10'h200; tick();
        check("jump_wins", addr16, 10'h200);
        clear_ctl();

        // Stall outranks Halt
        jump_to(10'h050);
        snap = m_cnt;
        stall = 1; halt = 1; tick(); tick();
        check("stall_pc", addr16, 10'h050);
        check("stall_running", run16, 1);
        check("stall_cnt", cnt16, snap + 2);
        stall = 0; tick(); halt = 0;
        check("halt_after_stall_done", done16, 1);
        check("halt_after_stall_pc", addr16, 10'h050);

        // Restart from DONE
        start = 1; start_addr = 10'h100; tick(); start = 0;
        check("restart_pc", addr16, 10'h100);
        check("restart_cnt", cnt16, 0);
        check("restart_done", done16, 0);
        check("restart_running", run16, 1);

        // Reset mid-run
        jump_to(10'h123);
        check("pre_reset_pc", addr16, 10'h123);
        reset_n = 0; tick(); reset_n = 1;
        check("midrun_reset_pc", addr16, 0);
        check("midrun_reset_running", run16, 0);

        // Saturation of the narrow counter
        start = 1; start_addr = 10'h000; tick(); start = 0;
        repeat (20) tick();
        check("sat_cnt4", cnt4, 15);
        check("sat_cnt16", cnt16, 20);
        tick();
        check("sat_cnt4_hold", cnt4, 15);

        // Random controls checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            reset_n     = ($urandom_range(0, 199) != 0);
            start       = ($urandom_range(0, 7) == 0);
            start_addr  = 10'($urandom);
            stall       = ($urandom_range(0, 5) == 0);
            halt        = ($urandom_range(0, 29) == 0);
            jump        = ($urandom_range(0, 7) == 0);
            jump_target = 10'($urandom);
            branch_rel  = ($urandom_range(0, 4) == 0);
            offset      = 6'($urandom);
            tick();
        end

        clear_ctl();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_ctr.md
# prog_ctr

Program counter and fetch sequencer for the core. It generates the 10-bit instruction address that drives the instruction ROM, and it consumes next-PC controls from the decoder: jump, relative branch, stall and halt. It also runs the start/done handshake with the testbench and counts execution cycles.

## Interface
Parameters:
- A, 10, instruction address width; must match the instruction ROM address width.
- OW, 6, width of the signed relative-branch offset.
- CW, 16, cycle counter width.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset_n  input  1  one clock; reset is synchronous and active-low.
- Start  input  1  request to begin execution at StartAddr.
- StartAddr  input  A  first instruction address.
- Stall  input  1  hold the current PC; the current instruction has not retired.
- Halt  input  1  the current instruction is a halt.
- Jump  input  1  take the absolute target JumpTarget.
- JumpTarget  input  A  absolute next PC.
- BranchRel  input  1  take the relative branch.
- Offset  input  OW  signed two's-complement branch offset.
- InstAddress  output  A  registered PC; feeds the ROM address port.
- Running  output  1  high while in RUN.
- Done  output  1  high while in DONE.
- CycleCnt  output  CW  count of RUN cycles, saturating.

## Operation
- The FSM has three states: IDLE, RUN and DONE. The state, PC and CycleCnt are all registers.
- Reset (Reset_n=0 at an edge) forces:
  - state to IDLE, InstAddress to 0 and CycleCnt to 0;
  - Running=0 and Done=0.
  - Reset overrides every other input, including in the middle of RUN.
- IDLE:
  - If Start=1, load PC with StartAddr, clear CycleCnt and go to RUN.
  - Otherwise hold.
- RUN: each edge, the first matching rule applies, in priority order:
  - Stall=1: PC holds. Halt, Jump and BranchRel are ignored.
  - Halt=1: PC holds and the state goes to DONE.
  - Jump=1: PC becomes JumpTarget.
  - BranchRel=1: PC becomes PC + sign_extend(Offset), modulo 2^A.
  - Otherwise: PC becomes PC + 1, modulo 2^A. The value 2^A-1 wraps to 0.
- Start is ignored while in RUN.
- CycleCnt increments on every RUN edge, including stalled cycles and the halting cycle. At 2^CW-1 it saturates and holds.
- DONE:
  - PC and CycleCnt hold.
  - Start=1 restarts exactly as from IDLE: PC becomes StartAddr, CycleCnt is cleared, and the state goes to RUN.
  - Because Done is a level, the testbench must drop Start before Done is checked; a held Start causes a restart.
- Arithmetic:
  - The offset is sign-extended from OW bits to A bits.
  - The sum is truncated to A bits. There is no overflow flag.

## Timing
- InstAddress is a registered output. The ROM is combinational, so the instruction at InstAddress is valid in the same cycle.
- Next-PC inputs (Stall, Halt, Jump, BranchRel, Offset, JumpTarget) are decoded combinationally from that instruction and sampled at the next edge.
- Start latency: Start is sampled high at edge N. After edge N:
  - InstAddress = StartAddr;
  - Running = 1;
  - CycleCnt = 0.
- Branch and jump latency: one cycle, with no delay slot. The new PC is visible immediately after the sampling edge.
- Halt is sampled at edge N. After edge N:
  - Running = 0 and Done = 1;
  - InstAddress still equals the halt instruction's address.
- Running and Done are registered, derived only from state, and never high together.

## Test plan
- Reset behaviour: hold Reset_n=0 for 2 cycles with Start=1 -> InstAddress=0, Running=0, Done=0, CycleCnt=0. Release reset with Start=1 and StartAddr=0x010 -> next cycle InstAddress=0x010 and Running=1.
- Sequential run and wrap: start at 0x3FE with no controls for 3 cycles -> InstAddress sequence 0x3FE, 0x3FF, 0x000, 0x001 and CycleCnt=3.
- Branches and priority:
  - At PC=0x020, BranchRel with Offset=6'b111100 (-4) -> 0x01C.
  - At PC=0x01C, Offset=+31 -> 0x03B.
  - At PC=0x03B, Jump=1 and BranchRel=1 with JumpTarget=0x200 -> 0x200 (Jump wins).
- Stall priority: at PC=0x050, Stall=1 and Halt=1 for 2 cycles -> PC stays 0x050, Running stays 1, CycleCnt advances by 2. Then drop Stall with Halt=1 -> Done=1, PC=0x050.
- Restart and Start-in-RUN:
  - Start pulsed during RUN -> ignored; the PC sequence is unaffected.
  - From DONE, Start with StartAddr=0x100 -> InstAddress=0x100, CycleCnt=0, Done=0, Running=1.
- Reset mid-run and saturation:
  - Assert Reset_n=0 at PC=0x123 during RUN -> IDLE and InstAddress=0 on the next cycle.
  - With CW overridden to 4, run 20 cycles -> CycleCnt=15 and holds there.
